// File: rtl/bootloader_loader_if.sv
// Byte-stream and status bundle between the bootloader loader and its neighbours.
// The slave side is the loader: it consumes UART bytes and drives memory writes and status.
interface bootloader_loader_if #(
   parameter int unsigned NB_BYTE   = 8,
   parameter int unsigned MEM_BYTES = 256
);
   localparam int unsigned NB_COUNT = $clog2(MEM_BYTES) + 1;

   logic                i_start;
   logic [NB_BYTE-1:0]  i_rx_data;
   logic                i_rx_valid;
   logic [NB_BYTE-1:0]  o_byte_de_bootloader;
   logic                o_bootloader_write_enable;
   logic                o_pc_reset;
   logic                o_busy;
   logic                o_load_done;
   logic                o_overflow_error;
   logic [NB_COUNT-1:0] o_byte_count;

   modport master (
      output i_start, i_rx_data, i_rx_valid,
      input  o_byte_de_bootloader, o_bootloader_write_enable, o_pc_reset,
      input  o_busy, o_load_done, o_overflow_error, o_byte_count
   );

   modport slave (
      input  i_start, i_rx_data, i_rx_valid,
      output o_byte_de_bootloader, o_bootloader_write_enable, o_pc_reset,
      output o_busy, o_load_done, o_overflow_error, o_byte_count
   );
endinterface

// File: rtl/bootloader_loader.sv
// Streams UART bytes into instruction memory, detects the aligned HALT word and then
// pulses a PC reset. Status flags are registered decodes of the previous state.
module bootloader_loader #(
   parameter int unsigned        NB_DATA   = 32,
   parameter int unsigned        NB_BYTE   = 8,
   parameter int unsigned        MEM_BYTES = 256,
   parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input logic                i_clk,
   input logic                i_reset,
   bootloader_loader_if.slave io_bus
);
   localparam int unsigned NB_COUNT       = $clog2(MEM_BYTES) + 1;
   localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
   localparam int unsigned NB_LANE        = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      StIdle,
      StReceive,
      StPcRst,
      StDone,
      StError
   } t_state;

   t_state              r_state;
   logic [NB_DATA-1:0]  r_word;
   logic [NB_COUNT-1:0] r_count;
   logic [NB_BYTE-1:0]  r_data;
   logic                r_we;
   logic                r_pc_reset;
   logic                r_busy;
   logic                r_done;
   logic                r_ovf;

   logic [NB_DATA-1:0]  w_word_next;
   logic [NB_COUNT-1:0] w_count_next;
   logic                w_halt;
   logic                w_full;

   assign w_word_next  = {r_word[NB_DATA-NB_BYTE-1:0], io_bus.i_rx_data};
   assign w_count_next = r_count + NB_COUNT'(1);
   // Only a byte that completes an aligned word may match HALT.
   assign w_halt       = (w_count_next[NB_LANE-1:0] == '0) && (w_word_next == HALT_WORD);
   assign w_full       = (w_count_next == NB_COUNT'(MEM_BYTES));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= StIdle;
         r_word     <= '0;
         r_count    <= '0;
         r_data     <= '0;
         r_we       <= 1'b0;
         r_pc_reset <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_we       <= 1'b0;
         r_pc_reset <= (r_state == StPcRst);
         r_busy     <= (r_state == StReceive) || (r_state == StPcRst);
         r_done     <= (r_state == StDone);
         r_ovf      <= (r_state == StError);
         case (r_state)
            StIdle, StDone, StError: begin
               // A byte arriving alongside start is dropped.
               if (io_bus.i_start) begin
                  r_state <= StReceive;
                  r_count <= '0;
                  r_word  <= '0;
               end
            end
            StReceive: begin
               if (io_bus.i_rx_valid) begin
                  r_we    <= 1'b1;
                  r_data  <= io_bus.i_rx_data;
                  r_word  <= w_word_next;
                  r_count <= w_count_next;
                  if (w_halt) begin
                     r_state <= StPcRst;
                  end else if (w_full) begin
                     r_state <= StError;
                  end
               end
            end
            StPcRst: r_state <= StDone;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.o_byte_de_bootloader      = r_data;
   assign io_bus.o_bootloader_write_enable = r_we;
   assign io_bus.o_pc_reset                = r_pc_reset;
   assign io_bus.o_busy                    = r_busy;
   assign io_bus.o_load_done               = r_done;
   assign io_bus.o_overflow_error          = r_ovf;
   assign io_bus.o_byte_count              = r_count;
endmodule

// File: tb/tb_bootloader_loader.sv
// Drives two loaders (256-byte and 8-byte memory) with the same byte stream and checks
// every cycle against a phase/count model, plus literal expectations per scenario.
module tb_bootloader_loader;
   localparam int PH_IDLE = 0;
   localparam int PH_RECV = 1;
   localparam int PH_PCRST = 2;
   localparam int PH_DONE = 3;
   localparam int PH_ERR = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       valid;
   logic [7:0] data;

   int n_checks = 0;
   int n_errors = 0;

   bootloader_loader_if #(.NB_BYTE(8), .MEM_BYTES(256)) bus_a ();
   bootloader_loader_if #(.NB_BYTE(8), .MEM_BYTES(8))   bus_b ();

   assign bus_a.i_start    = start;
   assign bus_a.i_rx_valid = valid;
   assign bus_a.i_rx_data  = data;
   assign bus_b.i_start    = start;
   assign bus_b.i_rx_valid = valid;
   assign bus_b.i_rx_data  = data;

   bootloader_loader #(.MEM_BYTES(256)) dut_a (.i_clk(clk), .i_reset(rst_n), .io_bus(bus_a));
   bootloader_loader #(.MEM_BYTES(8))   dut_b (.i_clk(clk), .i_reset(rst_n), .io_bus(bus_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: which phase of a load each instance is in, how many bytes it took,
   // and the last four bytes as a number. Flags report the phase of the previous cycle.
   int         ph[2]     = '{0, 0};
   int         cnt[2]    = '{0, 0};
   logic [31:0] word[2]  = '{0, 0};
   logic       e_we[2]   = '{0, 0};
   logic [7:0] e_data[2] = '{0, 0};
   logic       e_pc[2]   = '{0, 0};
   logic       e_busy[2] = '{0, 0};
   logic       e_done[2] = '{0, 0};
   logic       e_err[2]  = '{0, 0};

   always @(posedge clk or negedge rst_n) begin
      for (int m = 0; m < 2; m++) begin
         if (!rst_n) begin
            ph[m] = PH_IDLE; cnt[m] = 0; word[m] = '0;
            e_we[m] = 0; e_pc[m] = 0; e_busy[m] = 0; e_done[m] = 0; e_err[m] = 0;
         end else begin
            e_pc[m]   = (ph[m] == PH_PCRST);
            e_busy[m] = (ph[m] == PH_RECV) || (ph[m] == PH_PCRST);
            e_done[m] = (ph[m] == PH_DONE);
            e_err[m]  = (ph[m] == PH_ERR);
            e_we[m]   = 0;
            if (ph[m] == PH_RECV) begin
               if (valid) begin
                  e_we[m] = 1; e_data[m] = data;
                  word[m] = (word[m] << 8) | 32'(data);
                  cnt[m]++;
                  if ((cnt[m] % 4 == 0) && (word[m] == 32'hFFFF_FFFF)) ph[m] = PH_PCRST;
                  else if (cnt[m] == ((m == 0) ? 256 : 8)) ph[m] = PH_ERR;
               end
            end else if (ph[m] == PH_PCRST) begin
               ph[m] = PH_DONE;
            end else if (start) begin
               ph[m] = PH_RECV; cnt[m] = 0; word[m] = '0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cmp(input int m, input logic we, input logic [7:0] d, input logic pc,
                      input logic busy, input logic done, input logic err, input int count);
      string s;
      s = (m == 0) ? "a" : "b";
      check({s, ".we"}, 32'(we), 32'(e_we[m]));
      if (e_we[m]) check({s, ".data"}, 32'(d), 32'(e_data[m]));
      check({s, ".pc_reset"}, 32'(pc), 32'(e_pc[m]));
      check({s, ".busy"}, 32'(busy), 32'(e_busy[m]));
      check({s, ".load_done"}, 32'(done), 32'(e_done[m]));
      check({s, ".overflow"}, 32'(err), 32'(e_err[m]));
      check({s, ".count"}, 32'(count), 32'(cnt[m]));
   endtask

   int         pc_pulses_a = 0;
   int         writes_b    = 0;
   logic [7:0] log_a[$];

   always @(negedge clk) begin
      cmp(0, bus_a.o_bootloader_write_enable, bus_a.o_byte_de_bootloader, bus_a.o_pc_reset,
          bus_a.o_busy, bus_a.o_load_done, bus_a.o_overflow_error, int'(bus_a.o_byte_count));
      cmp(1, bus_b.o_bootloader_write_enable, bus_b.o_byte_de_bootloader, bus_b.o_pc_reset,
          bus_b.o_busy, bus_b.o_load_done, bus_b.o_overflow_error, int'(bus_b.o_byte_count));
      if (bus_a.o_pc_reset === 1'b1) pc_pulses_a++;
      if (bus_a.o_bootloader_write_enable === 1'b1) log_a.push_back(bus_a.o_byte_de_bootloader);
      if (bus_b.o_bootloader_write_enable === 1'b1) writes_b++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk); valid = 1'b1; data = b;
      @(negedge clk); valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   logic [7:0] prog[8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   logic [7:0] skew[8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

   initial begin
      rst_n = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00;
      #1 rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      check("reset.count_a", 32'(bus_a.o_byte_count), 0);
      check("reset.busy_a", 32'(bus_a.o_busy), 0);
      check("reset.done_b", 32'(bus_b.o_load_done), 0);

      // Byte in IDLE is ignored.
      send(8'hAB);
      idle(1);
      check("idle_byte.count_a", 32'(bus_a.o_byte_count), 0);

      // Normal load ending in HALT.
      pulse_start();
      log_a.delete();
      pc_pulses_a = 0;
      for (int i = 0; i < 8; i++) send(prog[i]);
      idle(4);
      check("load.writes_a", 32'(log_a.size()), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < log_a.size()) check($sformatf("load.byte%0d", i), 32'(log_a[i]), 32'(prog[i]));
      end
      check("load.pc_pulses_a", 32'(pc_pulses_a), 1);
      check("load.count_a", 32'(bus_a.o_byte_count), 8);
      check("load.done_a", 32'(bus_a.o_load_done), 1);
      check("load.busy_a", 32'(bus_a.o_busy), 0);
      check("load.done_b", 32'(bus_b.o_load_done), 1);

      // Byte in DONE is ignored.
      send(8'hAB);
      idle(1);
      check("done_byte.count_a", 32'(bus_a.o_byte_count), 8);

      // Misaligned HALT on a; overflow on the 8-byte b.
      pulse_start();
      writes_b = 0;
      for (int i = 0; i < 8; i++) send(skew[i]);
      idle(3);
      check("skew.pc_pulses_a", 32'(pc_pulses_a), 1);
      check("skew.count_a", 32'(bus_a.o_byte_count), 8);
      check("skew.busy_a", 32'(bus_a.o_busy), 1);
      check("ovf.err_b", 32'(bus_b.o_overflow_error), 1);
      check("ovf.busy_b", 32'(bus_b.o_busy), 0);
      send(8'h00);
      idle(1);
      check("ovf.writes_b", 32'(writes_b), 8);
      check("ovf.count_b", 32'(bus_b.o_byte_count), 8);
      check("skew.count9_a", 32'(bus_a.o_byte_count), 9);

      // Start recovers b from ERROR; a is mid-load and ignores it.
      pulse_start();
      idle(2);
      check("recover.err_b", 32'(bus_b.o_overflow_error), 0);
      check("recover.count_b", 32'(bus_b.o_byte_count), 0);
      send(8'h11); send(8'h22); send(8'h33);
      idle(1);
      check("recover.count_a", 32'(bus_a.o_byte_count), 12);
      check("recover.count_b", 32'(bus_b.o_byte_count), 3);

      // Asynchronous reset in mid-cycle.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async.count_a", 32'(bus_a.o_byte_count), 0);
      check("async.busy_a", 32'(bus_a.o_busy), 0);
      check("async.count_b", 32'(bus_b.o_byte_count), 0);
      check("async.busy_b", 32'(bus_b.o_busy), 0);
      idle(2);
      rst_n = 1'b1;

      // Start and byte together in IDLE: byte dropped.
      @(negedge clk); start = 1'b1; valid = 1'b1; data = 8'hAB;
      @(negedge clk); start = 1'b0; valid = 1'b0;
      idle(1);
      check("combo.count_a", 32'(bus_a.o_byte_count), 0);
      check("combo.busy_a", 32'(bus_a.o_busy), 1);
      for (int i = 0; i < 4; i++) send(8'hFF);
      idle(4);
      check("fresh.count_a", 32'(bus_a.o_byte_count), 4);
      check("fresh.done_a", 32'(bus_a.o_load_done), 1);
      check("fresh.count_b", 32'(bus_b.o_byte_count), 4);
      check("fresh.done_b", 32'(bus_b.o_load_done), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
